// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The frame FSM encoding and data width live here so the FIFO side and the engine agree.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Even parity makes the total count of ones even; odd flips it.
   function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// FIFO read port as seen by the transmit engine.
// The engine (master) issues pops; the FIFO (slave) provides the empty flag and read data.
interface uart_tx_engine_if;
   import uart_pkg::*;

   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      fifo_pop;

   modport master (input fifo_empty, input fifo_dout, output fifo_pop);
   modport slave  (output fifo_empty, output fifo_dout, input fifo_pop);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time down-counter: reloads at terminal count or on restart, flags the last clock of each bit.
// tick_next predicts bit_tick one clock ahead so the engine can register its end-of-frame pulse.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick,
   output logic             tick_next
);

   logic [DIV_W-1:0] cnt_reg;
   logic             reload;

   assign reload = restart || (cnt_reg == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (reload) begin
         cnt_reg <= div;
      end else begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign bit_tick  = (cnt_reg == '0);
   assign tick_next = reload ? (div == '0) : (cnt_reg == DIV_W'(1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the FIFO and frames them as start, 8 data LSB-first,
// optional parity and 1 or 2 stop bits. Outputs are registered alongside the state.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             two_stop,
   uart_tx_engine_if.master fifo,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   tx_state_t            state_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [3:0]           bit_cnt_reg;
   logic [DIV_W-1:0]     div_reg;
   logic                 parity_bit_reg;
   logic                 parity_en_reg;
   logic                 two_stop_reg;
   logic                 tx_reg;
   logic                 busy_reg;
   logic                 pop_reg;
   logic                 done_reg;

   logic             bit_tick;
   logic             tick_next;
   logic             restart;
   logic [DIV_W-1:0] gen_div;
   logic             last_data;
   logic             stop_last;

   // The counter is restarted in LOAD with the live divisor, which is latched on the same edge.
   assign restart   = (state_reg == LOAD);
   assign gen_div   = restart ? baud_div : div_reg;
   assign last_data = (bit_cnt_reg == 4'(DATA_BITS - 1));
   assign stop_last = (bit_cnt_reg == {3'b000, two_stop_reg});

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .div       (gen_div),
      .bit_tick  (bit_tick),
      .tick_next (tick_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         div_reg        <= '0;
         parity_bit_reg <= 1'b0;
         parity_en_reg  <= 1'b0;
         two_stop_reg   <= 1'b0;
         tx_reg         <= 1'b1;
         busy_reg       <= 1'b0;
         pop_reg        <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         pop_reg  <= 1'b0;
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (en && !fifo.fifo_empty) begin
                  state_reg <= FETCH;
                  pop_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            FETCH: begin
               state_reg <= LOAD;
            end
            LOAD: begin
               state_reg      <= START;
               shift_reg      <= fifo.fifo_dout;
               div_reg        <= baud_div;
               parity_en_reg  <= parity_en;
               two_stop_reg   <= two_stop;
               parity_bit_reg <= calc_parity(fifo.fifo_dout, parity_odd);
               bit_cnt_reg    <= '0;
               tx_reg         <= 1'b0;
            end
            START: begin
               if (bit_tick) begin
                  state_reg <= DATA;
                  tx_reg    <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (last_data) begin
                     bit_cnt_reg <= '0;
                     if (parity_en_reg) begin
                        state_reg <= PARITY;
                        tx_reg    <= parity_bit_reg;
                     end else begin
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                        done_reg  <= tick_next && !two_stop_reg;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     shift_reg   <= shift_reg >> 1;
                     tx_reg      <= shift_reg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state_reg <= STOP;
                  tx_reg    <= 1'b1;
                  done_reg  <= tick_next && !two_stop_reg;
               end
            end
            STOP: begin
               // done_reg is set one clock early so it lands on the final clock of the last stop bit.
               if (bit_tick) begin
                  if (stop_last) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     done_reg    <= tick_next;
                  end
               end else begin
                  done_reg <= tick_next && stop_last;
               end
            end
            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign tx            = tx_reg;
   assign busy          = busy_reg;
   assign tx_done       = done_reg;
   assign fifo.fifo_pop = pop_reg;

endmodule
